// File: rtl/vip_target_box_overlay.sv
// Target box overlay: snapshots the detector list at frame end, filters/compacts it, draws box borders next frame.
// Optional VIP_BOX_THICK2_EN: 2-pixel borders drawn inward (default 1 pixel).

module vip_box_edge_hit (
    input  logic       en,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] xmin,
    input  logic [9:0] xmax,
    input  logic [9:0] ymin,
    input  logic [9:0] ymax,
    output logic       hit
);
    logic on_v, on_h, in_x, in_y;

    always_comb begin
`ifdef VIP_BOX_THICK2_EN
        on_v = (x == xmin) || (x == xmin + 10'd1) || (x == xmax - 10'd1) || (x == xmax);
        on_h = (y == ymin) || (y == ymin + 10'd1) || (y == ymax - 10'd1) || (y == ymax);
`else
        on_v = (x == xmin) || (x == xmax);
        on_h = (y == ymin) || (y == ymax);
`endif
        in_x = (x >= xmin) && (x <= xmax);
        in_y = (y >= ymin) && (y <= ymax);
        hit  = en && ((on_v && in_y) || (on_h && in_x));
    end
endmodule

module vip_target_box_overlay #(
    parameter logic [9:0]  IMG_HDISP = 10'd640,
    parameter logic [9:0]  IMG_VDISP = 10'd480,
    parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              per_frame_vsync,
    input  logic              per_frame_hsync,
    input  logic              per_frame_clken,
    input  logic [23:0]       per_img_data,
    input  logic [15:0][40:0] target_pos_in,
    input  logic [9:0]        min_size,
    input  logic              disp_sel,
    output logic              post_frame_vsync,
    output logic              post_frame_hsync,
    output logic              post_frame_clken,
    output logic [23:0]       post_img_data,
    output logic [4:0]        target_count
);
    localparam int NUM_LANES = 16;

    if (IMG_HDISP < 10'd2 || IMG_VDISP == 10'd0) begin : g_param_chk
        $error("vip_target_box_overlay: bad frame geometry");
    end

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                       state;
    logic [3:0]                   idx;
    logic [4:0]                   pend_cnt;
    logic                         bank_ok;
    logic                         vsync_r;
    logic                         rise, fall;
    logic [NUM_LANES-1:0][39:0]   pend;
    logic [NUM_LANES-1:0][39:0]   bank;

    logic [40:0] cur;
    logic [9:0]  cur_w, cur_h;
    logic        keep;

    assign rise = ~vsync_r & per_frame_vsync;
    assign fall = vsync_r & ~per_frame_vsync;
    assign cur  = target_pos_in[idx];

    // Reversed corners are rejected explicitly since the 10-bit difference would wrap large.
    always_comb begin
        cur_w = cur[29:20] - cur[9:0];
        cur_h = cur[39:30] - cur[19:10];
        keep  = cur[40] && (cur[29:20] >= cur[9:0]) && (cur[39:30] >= cur[19:10])
                && (cur_w >= min_size) && (cur_h >= min_size);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            pend_cnt     <= '0;
            bank_ok      <= 1'b0;
            vsync_r      <= 1'b0;
            pend         <= '0;
            bank         <= '0;
            target_count <= '0;
        end else begin
            vsync_r <= per_frame_vsync;
            case (state)
                IDLE: if (rise) begin
                    idx      <= '0;
                    pend_cnt <= '0;
                    state    <= SCAN;
                end
                SCAN: if (fall) begin
                    // vsync too short to finish the list: keep the previous bank
                    state <= IDLE;
                end else begin
                    if (keep) begin
                        pend[pend_cnt[3:0]] <= cur[39:0];
                        pend_cnt            <= pend_cnt + 5'd1;
                    end
                    if (idx == 4'd15) begin
                        state   <= DONE;
                        bank_ok <= 1'b1;
                    end
                    idx <= idx + 4'd1;
                end
                DONE: if (fall) begin
                    if (bank_ok) begin
                        bank         <= pend;
                        target_count <= pend_cnt;
                    end
                    bank_ok <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [9:0] x_cnt, y_cnt;

    // y_cnt is left to wrap naturally; vsync is the only frame restart.
    always_ff @(posedge clk) begin
        if (rst || per_frame_vsync) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (per_frame_clken) begin
            if (x_cnt == IMG_HDISP - 10'd1) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + 10'd1;
            end else begin
                x_cnt <= x_cnt + 10'd1;
            end
        end
    end

    logic [NUM_LANES-1:0] hit;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        vip_box_edge_hit u_hit (
            .en   (5'(k) < target_count),
            .x    (x_cnt),
            .y    (y_cnt),
            .xmin (bank[k][9:0]),
            .xmax (bank[k][29:20]),
            .ymin (bank[k][19:10]),
            .ymax (bank[k][39:30]),
            .hit  (hit[k])
        );
    end

    logic        any_hit_r, disp_sel_r;
    logic [23:0] data_r;
    logic [2:0]  sync_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            any_hit_r        <= 1'b0;
            disp_sel_r       <= 1'b0;
            data_r           <= '0;
            sync_r           <= '0;
            post_frame_vsync <= 1'b0;
            post_frame_hsync <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_data    <= '0;
        end else begin
            any_hit_r        <= |hit;
            disp_sel_r       <= disp_sel;
            data_r           <= per_img_data;
            sync_r           <= {per_frame_vsync, per_frame_hsync, per_frame_clken};
            post_frame_vsync <= sync_r[2];
            post_frame_hsync <= sync_r[1];
            post_frame_clken <= sync_r[0];
            post_img_data    <= (disp_sel_r && any_hit_r && sync_r[0]) ? BOX_COLOR : data_r;
        end
    end
endmodule

// File: tb/tb_vip_target_box_overlay.sv
// Directed bench for vip_target_box_overlay: short frames on a 160-pixel line, hand-picked boxes and spot pixels.
module tb_vip_target_box_overlay;
    localparam int HD = 160;

    logic              clk = 1'b0;
    logic              rst;
    logic              per_frame_vsync, per_frame_hsync, per_frame_clken;
    logic [23:0]       per_img_data;
    logic [15:0][40:0] target_pos_in;
    logic [9:0]        min_size;
    logic              disp_sel;
    logic              post_frame_vsync, post_frame_hsync, post_frame_clken;
    logic [23:0]       post_img_data;
    logic [4:0]        target_count;

    always #5 clk = ~clk;

    vip_target_box_overlay #(.IMG_HDISP(10'd160)) dut (
        .clk              (clk),
        .rst              (rst),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_hsync  (per_frame_hsync),
        .per_frame_clken  (per_frame_clken),
        .per_img_data     (per_img_data),
        .target_pos_in    (target_pos_in),
        .min_size         (min_size),
        .disp_sel         (disp_sel),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_hsync (post_frame_hsync),
        .post_frame_clken (post_frame_clken),
        .post_img_data    (post_img_data),
        .target_count     (target_count)
    );

    int n_tests = 0, n_fail = 0;
    int pix_err = 0, sync_err = 0;
    int nb = 0;
    int bx0 [4], by0 [4], bx1 [4], by1 [4];
    logic [23:0] cap [0:255][0:HD-1];

    logic [23:0] h_data;
    logic        h_vs, h_hs, h_ce, h_disp;
    int          h_x, h_y;
    bit          h_ok = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [40:0] ent(input bit f, input int x0, input int y0, input int x1, input int y1);
        return {f, 10'(y1), 10'(x1), 10'(y0), 10'(x0)};
    endfunction

    function automatic bit in_box(input int x, input int y);
        for (int k = 0; k < nb; k++) begin
            bit ov, oh;
`ifdef VIP_BOX_THICK2_EN
            ov = (x == bx0[k]) || (x == bx0[k] + 1) || (x == bx1[k] - 1) || (x == bx1[k]);
            oh = (y == by0[k]) || (y == by0[k] + 1) || (y == by1[k] - 1) || (y == by1[k]);
`else
            ov = (x == bx0[k]) || (x == bx1[k]);
            oh = (y == by0[k]) || (y == by1[k]);
`endif
            if ((ov && y >= by0[k] && y <= by1[k]) || (oh && x >= bx0[k] && x <= bx1[k]))
                return 1;
        end
        return 0;
    endfunction

    function automatic logic [23:0] pix(input int x, input int y);
        return {8'h3C, 8'(y), 8'(x)};
    endfunction

    task automatic set_box(input int k, input int x0, input int y0, input int x1, input int y1);
        bx0[k] = x0; by0[k] = y0; bx1[k] = x1; by1[k] = y1;
    endtask

    // One clock: outputs after this edge belong to the inputs applied one step earlier.
    task automatic step(input int x, input int y);
        logic [23:0] e;
        @(posedge clk); #1;
        if (h_ok) begin
            e = (h_disp && h_ce && in_box(h_x, h_y)) ? 24'hFF0000 : h_data;
            if (post_img_data !== e) pix_err++;
            if ({post_frame_vsync, post_frame_hsync, post_frame_clken} !== {h_vs, h_hs, h_ce}) sync_err++;
            if (h_ce && h_y < 256 && h_x < HD) cap[h_y][h_x] = post_img_data;
        end
        h_data = per_img_data; h_vs = per_frame_vsync; h_hs = per_frame_hsync;
        h_ce = per_frame_clken; h_disp = disp_sel; h_x = x; h_y = y; h_ok = 1;
    endtask

    task automatic vs_pulse(input int n);
        per_frame_vsync = 1; per_frame_hsync = 0; per_frame_clken = 0;
        for (int i = 0; i < n; i++) step(0, 0);
        per_frame_vsync = 0;
        for (int i = 0; i < 4; i++) step(0, 0);
    endtask

    task automatic frame(input string tag, input int nl);
        for (int y = 0; y < nl; y++) begin
            per_frame_hsync = 1;
            for (int x = 0; x < HD; x++) begin
                per_frame_clken = 1;
                per_img_data = pix(x, y);
                step(x, y);
            end
            per_frame_hsync = 0; per_frame_clken = 0;
            step(0, 0); step(0, 0);
        end
        step(0, 0); step(0, 0);
        chk({tag, "_pix"}, pix_err, 0);
        chk({tag, "_sync"}, sync_err, 0);
        pix_err = 0; sync_err = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        h_ok = 0;
    endtask

    initial begin
        per_frame_vsync = 0; per_frame_hsync = 0; per_frame_clken = 0;
        per_img_data = 24'h123456; target_pos_in = '0; min_size = 10'd10; disp_sel = 1;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tc", target_count, 0);
        chk("rst_data", post_img_data, 0);
        chk("rst_syncs", {post_frame_vsync, post_frame_hsync, post_frame_clken}, 0);
        rst = 0;

        // no flagged entries: pure pass-through
        nb = 0;
        vs_pulse(40);
        chk("noflag_tc", target_count, 0);
        frame("noflag", 4);

        // single box from the detector, large frame
        target_pos_in[0] = ent(1, 50, 100, 150, 200);
        vs_pulse(40);
        chk("one_tc", target_count, 1);
        nb = 1; set_box(0, 50, 100, 150, 200);
        frame("one", 202);
        chk("p50_100", cap[100][50], 24'hFF0000);
        chk("p150_200", cap[200][150], 24'hFF0000);
        chk("p100_100", cap[100][100], 24'hFF0000);
        chk("p50_150", cap[150][50], 24'hFF0000);
        chk("p51_101", cap[101][51], pix(51, 101));
        chk("p49_100", cap[100][49], pix(49, 100));

        // compaction: narrow entry and unflagged entry dropped
        target_pos_in = '0;
        target_pos_in[0] = ent(1, 0, 0, 5, 20);
        target_pos_in[1] = ent(0, 20, 0, 40, 20);
        target_pos_in[2] = ent(1, 60, 2, 80, 22);
        vs_pulse(40);
        chk("cmp_tc", target_count, 1);
        nb = 1; set_box(0, 60, 2, 80, 22);
        frame("cmp", 24);
        chk("cmp_60_2", cap[2][60], 24'hFF0000);
        chk("cmp_80_12", cap[12][80], 24'hFF0000);
        chk("cmp_20_0", cap[0][20], pix(20, 0));
        chk("cmp_0_10", cap[10][0], pix(0, 10));

        // width exactly min_size kept, reversed and 9-wide rejected; then short vsync aborts
        target_pos_in = '0;
        target_pos_in[0] = ent(1, 100, 30, 110, 40);
        target_pos_in[1] = ent(1, 100, 0, 5, 20);
        target_pos_in[2] = ent(1, 10, 5, 30, 25);
        target_pos_in[3] = ent(1, 0, 0, 9, 50);
        vs_pulse(40);
        chk("two_tc", target_count, 2);
        nb = 2; set_box(0, 100, 30, 110, 40); set_box(1, 10, 5, 30, 25);
        frame("two", 42);
        chk("two_110_40", cap[40][110], 24'hFF0000);
        chk("two_10_5", cap[5][10], 24'hFF0000);
        chk("two_0_0", cap[0][0], pix(0, 0));
        target_pos_in = '0;
        vs_pulse(8);
        chk("abort_tc", target_count, 2);
        frame("abort", 42);
        chk("abort_100_35", cap[35][100], 24'hFF0000);

        // three boxes, display disabled; 17-cycle vsync is just long enough
        target_pos_in[0] = ent(1, 10, 5, 30, 25);
        target_pos_in[1] = ent(1, 40, 1, 60, 21);
        target_pos_in[2] = ent(1, 70, 0, 90, 20);
        disp_sel = 0;
        vs_pulse(17);
        chk("nodisp_tc", target_count, 3);
        nb = 3; set_box(0, 10, 5, 30, 25); set_box(1, 40, 1, 60, 21); set_box(2, 70, 0, 90, 20);
        frame("nodisp", 24);
        chk("nodisp_10_5", cap[5][10], pix(10, 5));

        // reset in the middle of a scan
        disp_sel = 1;
        per_frame_vsync = 1;
        for (int i = 0; i < 8; i++) step(0, 0);
        rst = 1; per_frame_vsync = 0;
        @(posedge clk); #1;
        chk("mid_rst_tc", target_count, 0);
        chk("mid_rst_data", post_img_data, 0);
        chk("mid_rst_syncs", {post_frame_vsync, post_frame_hsync, post_frame_clken}, 0);
        rst = 0; h_ok = 0;

        // degenerate single-pixel box with min_size 0
        target_pos_in = '0;
        target_pos_in[0] = ent(1, 7, 3, 7, 3);
        target_pos_in[1] = ent(1, 20, 2, 40, 12);
        min_size = 10'd0;
        nb = 0;
        vs_pulse(40);
        chk("post_rst_tc", target_count, 2);
        nb = 2; set_box(0, 7, 3, 7, 3); set_box(1, 20, 2, 40, 12);
        frame("post_rst", 14);
        chk("dgn_7_3", cap[3][7], 24'hFF0000);
        chk("dgn_8_3", cap[3][8], pix(8, 3));
        chk("dgn_7_4", cap[4][7], pix(7, 4));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
